reorder_buffer: RTL and testbench
=================================

# reorder_buffer

Circular reorder buffer for the out-of-order core. It sits between issue/dispatch and the architectural register file. It allocates one tagged entry per issued instruction and captures results from the common data bus. It retires entries in program order, driving the register file's commit port (`commit_rd`, `commit_value`, `commit_tag`), and raises a pipeline flush when a mispredicted branch retires.

## Interface
Parameters:
- `ROB_DEPTH`, default 16: number of entries. Must be a power of two, at least 2.
- `TAG_W`, default 5: equals log2(`ROB_DEPTH`)+1.
  - Tag = slot index + 1.
  - Tag 0 is reserved and means "no producer / value ready".

Ports:
- `clk` in 1: clock.
- `rst` in 1: reset, synchronous, active-high.
- `rdy` in 1: when low, all state is frozen.
- `alloc_valid` in 1: issue requests an entry this cycle.
- `alloc_rd` in 5: destination register. 0 means no register write.
- `alloc_is_branch` in 1: the entry is a branch.
- `alloc_ready` out 1: combinational, high when count < `ROB_DEPTH`.
- `alloc_tag` out `TAG_W`: combinational, tail index + 1. This is the tag given to the current allocation.
- `wb_valid` in 1: CDB result valid.
- `wb_tag` in `TAG_W`: tag of the result.
- `wb_value` in 32: result value.
- `wb_mispredict` in 1: the branch resolved against its prediction.
- `wb_target` in 32: correct PC for a mispredicted branch.
- `commit_valid` out 1: registered, one-cycle pulse per retired entry.
- `commit_wen` out 1: registered, `commit_valid` && rd≠0.
- `commit_rd` out 5: retired destination register.
- `commit_value` out 32: retired value.
- `commit_tag` out `TAG_W`: tag of the retired entry. The register file clears its busy bit only if the stored tag matches.
- `flush` out 1: registered, one-cycle pulse.
- `flush_pc` out 32: redirect PC, valid while `flush` is high.

## Operation
- Per-entry state: `busy`, `ready`, `rd`, `value`, `is_branch`, `mispredict`, `target`. Pointers `head` and `tail` are index-width and wrap modulo `ROB_DEPTH`. `count` is `TAG_W` bits wide.
- Allocate: fires when `alloc_valid && alloc_ready`. Sets the tail entry to busy=1, ready=0, records rd and is_branch, then advances tail. When `alloc_ready`=0, `alloc_valid` is ignored and nothing is allocated.
- Writeback: fires when `wb_valid`, `wb_tag`≠0, and the addressed entry is busy. Sets ready=1 and latches value, mispredict and target. Writebacks to tag 0 or to a non-busy entry are ignored.
- Commit: when the head entry is busy and ready, retire it. Clear busy, advance head, decrement count, and drive the `commit_*` outputs at that edge.
- Flush: if the retiring entry has is_branch && mispredict, also assert `flush` and set `flush_pc`=target. At the same edge, clear every busy bit and set head=tail=0, count=0. An allocation in that cycle is discarded.
- Count update: count += alloc_fire − commit_fire. Allocate and commit may both fire in one cycle.
- Reset: all entries not busy, head=tail=count=0. All registered outputs are 0.

## Timing
- `alloc_tag` and `alloc_ready` are combinational from the current state. `alloc_ready` reflects count before any same-cycle commit, so a full buffer never reuses a slot in the cycle it frees it.
- A writeback at edge N makes the entry ready. The earliest commit of that entry is at edge N+1, i.e. `commit_valid` is visible in cycle N+1.
- Commit throughput: at most one entry per cycle.
- `commit_valid`, `commit_wen` and `flush` are high for exactly one cycle, and are 0 in any cycle where nothing retired.
- `rdy` low at an edge: no state change, and `commit_valid`, `commit_wen`, `flush` are driven 0.
- Wrap-around: tail at slot `ROB_DEPTH`−1 followed by an allocate gives tail=0. The next `alloc_tag` is 1.
- `rst` asserted mid-operation overrides allocate, writeback and commit at that edge.

## Configuration
- `ROB_BYPASS_EN` defined:
  - Adds inputs `q1_tag`, `q2_tag` (`TAG_W` each).
  - Adds outputs `q1_ready`, `q2_ready` (1 bit each) and `q1_value`, `q2_value` (32 bits each).
  - Outputs are combinational. For a nonzero tag whose entry is busy and ready, return ready=1 and the entry value. A same-cycle matching CDB writeback is also forwarded. Otherwise return ready=0, value 0.
  - Dispatch then reads completed-but-uncommitted producers.
- `ROB_BYPASS_EN` undefined: these ports are absent, and dispatch must wait for commit or for the CDB.

## Test plan
- Reset: `alloc_tag`=1, `alloc_ready`=1, `commit_valid`=0, `flush`=0.
- In-order retire:
  - Stimulus: allocate rd=3, 5, 7 (tags 1, 2, 3); write back tag 3 then 2 then 1 with values 0x33, 0x22, 0x11.
  - Response: commits tag1/rd3/0x11, tag2/rd5/0x22, tag3/rd7/0x33 on consecutive cycles, starting the cycle after the tag-1 writeback.
- Full and wrap:
  - Stimulus: allocate 16 entries without writeback.
  - Response: `alloc_ready`=0, and a 17th `alloc_valid` is ignored.
  - Stimulus: write back tag 1, then allocate.
  - Response: after tag 1 retires, `alloc_ready`=1 and `alloc_tag`=1.
- rd=0 entry written back: `commit_valid`=1, `commit_wen`=0.
- Mispredict:
  - Stimulus: branch at tag 2 written back with mispredict=1, target=0x1000; tags 3 and 4 busy.
  - Response: tag 2 commit coincides with `flush`=1, `flush_pc`=0x1000. Next cycle `alloc_tag`=1, count=0, and no further commits.
- `rdy` low for 3 cycles with the head entry ready: no commit during the stall. Commit occurs on the first edge with `rdy` high.
- Bypass (`ROB_BYPASS_EN` defined): with tag 2 ready holding 0xABCD, `q1_tag`=2 gives `q1_ready`=1, `q1_value`=0xABCD.

Source files
------------

// File: rtl/reorder_buffer.sv
// Circular reorder buffer: allocates tagged entries, captures CDB results, retires in order, flushes on mispredict.
// Optional ROB_BYPASS_EN adds two combinational operand lookup ports for dispatch.
module reorder_buffer #(
    parameter int ROB_DEPTH = 16,
    parameter int TAG_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             alloc_valid,
    input  logic [4:0]       alloc_rd,
    input  logic             alloc_is_branch,
    output logic             alloc_ready,
    output logic [TAG_W-1:0] alloc_tag,
    input  logic             wb_valid,
    input  logic [TAG_W-1:0] wb_tag,
    input  logic [31:0]      wb_value,
    input  logic             wb_mispredict,
    input  logic [31:0]      wb_target,
`ifdef ROB_BYPASS_EN
    input  logic [TAG_W-1:0] q1_tag,
    input  logic [TAG_W-1:0] q2_tag,
    output logic             q1_ready,
    output logic             q2_ready,
    output logic [31:0]      q1_value,
    output logic [31:0]      q2_value,
`endif
    output logic             commit_valid,
    output logic             commit_wen,
    output logic [4:0]       commit_rd,
    output logic [31:0]      commit_value,
    output logic [TAG_W-1:0] commit_tag,
    output logic             flush,
    output logic [31:0]      flush_pc
);
    localparam int IDX_W = TAG_W - 1;

    logic [ROB_DEPTH-1:0] busy, ready, is_branch, mispredict;
    logic [4:0]           rd_q     [ROB_DEPTH];
    logic [31:0]          value_q  [ROB_DEPTH];
    logic [31:0]          target_q [ROB_DEPTH];
    logic [IDX_W-1:0]     head, tail;
    logic [TAG_W-1:0]     count;

    logic [IDX_W-1:0] wb_idx;
    logic             wb_tag_ok, wb_fire, alloc_fire, commit_fire, do_flush;

    assign alloc_ready = count < TAG_W'(ROB_DEPTH);
    assign alloc_tag   = TAG_W'({1'b0, tail}) + TAG_W'(1);

    // Tags above ROB_DEPTH name no slot and are dropped like tag 0.
    assign wb_idx      = IDX_W'(wb_tag - TAG_W'(1));
    assign wb_tag_ok   = (wb_tag != '0) && (wb_tag <= TAG_W'(ROB_DEPTH));
    assign wb_fire     = wb_valid && wb_tag_ok && busy[wb_idx];
    assign alloc_fire  = alloc_valid && alloc_ready;
    assign commit_fire = busy[head] && ready[head];
    assign do_flush    = commit_fire && is_branch[head] && mispredict[head];

    always_ff @(posedge clk) begin
        if (rst) begin
            busy         <= '0;
            ready        <= '0;
            is_branch    <= '0;
            mispredict   <= '0;
            head         <= '0;
            tail         <= '0;
            count        <= '0;
            commit_valid <= 1'b0;
            commit_wen   <= 1'b0;
            commit_rd    <= '0;
            commit_value <= '0;
            commit_tag   <= '0;
            flush        <= 1'b0;
            flush_pc     <= '0;
            for (int i = 0; i < ROB_DEPTH; i++) begin
                rd_q[i]     <= '0;
                value_q[i]  <= '0;
                target_q[i] <= '0;
            end
        end else begin
            commit_valid <= 1'b0;
            commit_wen   <= 1'b0;
            flush        <= 1'b0;
            if (rdy) begin
                if (wb_fire) begin
                    ready[wb_idx]      <= 1'b1;
                    value_q[wb_idx]    <= wb_value;
                    mispredict[wb_idx] <= wb_mispredict;
                    target_q[wb_idx]   <= wb_target;
                end
                // The tail slot is never busy when alloc fires, so it cannot collide with a writeback.
                if (alloc_fire) begin
                    busy[tail]      <= 1'b1;
                    ready[tail]     <= 1'b0;
                    rd_q[tail]      <= alloc_rd;
                    is_branch[tail] <= alloc_is_branch;
                    tail            <= tail + IDX_W'(1);
                end
                if (commit_fire) begin
                    busy[head]   <= 1'b0;
                    head         <= head + IDX_W'(1);
                    commit_valid <= 1'b1;
                    commit_wen   <= rd_q[head] != 5'd0;
                    commit_rd    <= rd_q[head];
                    commit_value <= value_q[head];
                    commit_tag   <= TAG_W'({1'b0, head}) + TAG_W'(1);
                end
                count <= count + TAG_W'(alloc_fire) - TAG_W'(commit_fire);
                // Flush overrides the allocate and pointer updates above.
                if (do_flush) begin
                    busy     <= '0;
                    head     <= '0;
                    tail     <= '0;
                    count    <= '0;
                    flush    <= 1'b1;
                    flush_pc <= target_q[head];
                end
            end
        end
    end

`ifdef ROB_BYPASS_EN
    // Returns {ready, value}; a stored result wins over a same-cycle CDB match.
    function automatic logic [32:0] lookup(input logic [TAG_W-1:0] t);
        logic [IDX_W-1:0] i;
        logic             hit;
        i      = IDX_W'(t - TAG_W'(1));
        hit    = (t != '0) && (t <= TAG_W'(ROB_DEPTH)) && busy[i];
        lookup = '0;
        if (hit && ready[i])
            lookup = {1'b1, value_q[i]};
        else if (hit && wb_valid && wb_tag == t)
            lookup = {1'b1, wb_value};
    endfunction

    always_comb begin
        {q1_ready, q1_value} = lookup(q1_tag);
        {q2_ready, q2_value} = lookup(q2_tag);
    end
`endif

endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: directed scenarios then random traffic, all checked against an in-order queue model.
module tb_reorder_buffer;
    localparam int DEPTH = 16;
    localparam int TW    = 5;

    logic          clk = 1'b0;
    logic          rst, rdy;
    logic          alloc_valid, alloc_is_branch, alloc_ready;
    logic [4:0]    alloc_rd;
    logic [TW-1:0] alloc_tag;
    logic          wb_valid, wb_mispredict;
    logic [TW-1:0] wb_tag;
    logic [31:0]   wb_value, wb_target;
    logic          commit_valid, commit_wen, flush;
    logic [4:0]    commit_rd;
    logic [31:0]   commit_value, flush_pc;
    logic [TW-1:0] commit_tag;
`ifdef ROB_BYPASS_EN
    logic [TW-1:0] q1_tag, q2_tag;
    logic          q1_ready, q2_ready;
    logic [31:0]   q1_value, q2_value;
`endif

    always #5 clk = ~clk;

    reorder_buffer #(.ROB_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .rst(rst), .rdy(rdy),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_is_branch(alloc_is_branch),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_value(wb_value),
        .wb_mispredict(wb_mispredict), .wb_target(wb_target),
`ifdef ROB_BYPASS_EN
        .q1_tag(q1_tag), .q2_tag(q2_tag), .q1_ready(q1_ready), .q2_ready(q2_ready),
        .q1_value(q1_value), .q2_value(q2_value),
`endif
        .commit_valid(commit_valid), .commit_wen(commit_wen), .commit_rd(commit_rd),
        .commit_value(commit_value), .commit_tag(commit_tag),
        .flush(flush), .flush_pc(flush_pc)
    );

    // Reference model: in-flight instructions in program order, oldest first.
    typedef struct {
        logic [4:0]  tag;
        logic [4:0]  rd;
        bit          br;
        bit          done;
        logic [31:0] val;
        bit          mp;
        logic [31:0] tgt;
    } ent_t;

    ent_t mq[$];
    int   next_slot;
    int   n_checks, n_fail;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        alloc_valid = 0; alloc_rd = 0; alloc_is_branch = 0;
        wb_valid = 0; wb_tag = 0; wb_value = 0; wb_mispredict = 0; wb_target = 0;
        rdy = 1;
`ifdef ROB_BYPASS_EN
        q1_tag = 0; q2_tag = 0;
`endif
    endtask

`ifdef ROB_BYPASS_EN
    function automatic logic [32:0] model_lookup(input logic [TW-1:0] t);
        model_lookup = '0;
        foreach (mq[i]) if (t != 0 && mq[i].tag == t) begin
            if (mq[i].done) model_lookup = {1'b1, mq[i].val};
            else if (wb_valid && wb_tag == t) model_lookup = {1'b1, wb_value};
        end
    endfunction
`endif

    // One clock: check combinational outputs, step the model, then check registered outputs.
    task automatic cycle();
        bit   exp_cv, exp_fl;
        ent_t h, e;
        chk("alloc_ready", alloc_ready, mq.size() < DEPTH);
        chk("alloc_tag", alloc_tag, next_slot + 1);
`ifdef ROB_BYPASS_EN
        chk("q1_bypass", {q1_ready, q1_value}, model_lookup(q1_tag));
        chk("q2_bypass", {q2_ready, q2_value}, model_lookup(q2_tag));
`endif
        exp_cv = 0; exp_fl = 0;
        if (rdy) begin
            if (mq.size() > 0 && mq[0].done) begin
                exp_cv = 1; h = mq[0]; exp_fl = h.br && h.mp;
            end
            if (wb_valid && wb_tag != 0)
                foreach (mq[i]) if (mq[i].tag == wb_tag) begin
                    mq[i].done = 1; mq[i].val = wb_value;
                    mq[i].mp = wb_mispredict; mq[i].tgt = wb_target;
                end
            if (alloc_valid && mq.size() < DEPTH) begin
                e.tag = 5'(next_slot + 1); e.rd = alloc_rd; e.br = alloc_is_branch;
                e.done = 0; e.val = 0; e.mp = 0; e.tgt = 0;
                mq.push_back(e);
                next_slot = (next_slot + 1) % DEPTH;
            end
            if (exp_cv) void'(mq.pop_front());
            if (exp_fl) begin mq.delete(); next_slot = 0; end
        end
        @(posedge clk); #1;
        chk("commit_valid", commit_valid, exp_cv);
        chk("flush", flush, exp_fl);
        if (exp_cv) begin
            chk("commit_tag", commit_tag, h.tag);
            chk("commit_rd", commit_rd, h.rd);
            chk("commit_value", commit_value, h.val);
            chk("commit_wen", commit_wen, h.rd != 0);
        end else begin
            chk("commit_wen_idle", commit_wen, 0);
        end
        if (exp_fl) chk("flush_pc", flush_pc, h.tgt);
    endtask

    task automatic do_reset(input bit noisy);
        rst = 1;
        if (noisy) begin
            alloc_valid = 1; alloc_rd = 5'd9; wb_valid = 1; wb_tag = 5'd1; wb_value = 32'hdead;
        end
        @(posedge clk); #1;
        rst = 0;
        idle_inputs();
        mq.delete(); next_slot = 0;
        chk("rst_commit_valid", commit_valid, 0);
        chk("rst_flush", flush, 0);
        chk("rst_alloc_tag", alloc_tag, 1);
        chk("rst_alloc_ready", alloc_ready, 1);
    endtask

    task automatic alloc(input logic [4:0] rd, input bit br);
        alloc_valid = 1; alloc_rd = rd; alloc_is_branch = br;
        cycle();
        idle_inputs();
    endtask

    task automatic wb(input logic [TW-1:0] t, input logic [31:0] v, input bit mp, input logic [31:0] tgt);
        wb_valid = 1; wb_tag = t; wb_value = v; wb_mispredict = mp; wb_target = tgt;
        cycle();
        idle_inputs();
    endtask

    // Write back pending entries in random order until the model is empty.
    task automatic drain();
        int budget = 200;
        while (mq.size() > 0 && budget > 0) begin
            int pend[$];
            foreach (mq[i]) if (!mq[i].done) pend.push_back(i);
            if (pend.size() > 0) begin
                int k = pend[$urandom_range(0, pend.size() - 1)];
                wb_valid = 1; wb_tag = mq[k].tag; wb_value = $urandom; wb_mispredict = 0;
            end
            cycle();
            idle_inputs();
            budget--;
        end
        chk("drain_timeout", budget > 0, 1);
    endtask

    initial begin
        n_checks = 0; n_fail = 0;
        idle_inputs();
        rst = 1;
        repeat (2) @(posedge clk);
        #1;
        do_reset(0);

        // In-order retire with out-of-order writeback.
        alloc(5'd3, 0); alloc(5'd5, 0); alloc(5'd7, 0);
        wb(5'd3, 32'h33, 0, 0);
        wb(5'd2, 32'h22, 0, 0);
        wb(5'd1, 32'h11, 0, 0);
        repeat (4) cycle();
        chk("inorder_empty_tag", alloc_tag, 4);

        // Full buffer, ignored 17th allocate, retire and wrap to tag 1.
        do_reset(0);
        for (int i = 0; i < DEPTH; i++) alloc(5'(i + 1), 0);
        chk("full_alloc_ready", alloc_ready, 0);
        alloc(5'd30, 0);
        wb(5'd1, 32'h1111, 0, 0);
        cycle();
        chk("wrap_alloc_ready", alloc_ready, 1);
        chk("wrap_alloc_tag", alloc_tag, 1);
        alloc(5'd0, 0);
        drain();

        // Mispredicted branch at tag 2 with younger entries busy; allocate during flush is dropped.
        do_reset(0);
        alloc(5'd1, 0); alloc(5'd0, 1); alloc(5'd4, 0); alloc(5'd6, 0);
        wb(5'd1, 32'haa, 0, 0);
        wb(5'd2, 32'hbb, 1, 32'h1000);
        alloc_valid = 1; alloc_rd = 5'd9;
        cycle();
        idle_inputs();
        chk("flush_seen", flush, 1);
        chk("flush_pc_dir", flush_pc, 32'h1000);
        chk("post_flush_tag", alloc_tag, 1);
        wb(5'd3, 32'hcc, 0, 0);
        repeat (3) cycle();

        // Stall with ready head entry.
        alloc(5'd8, 0);
        wb(5'd1, 32'h5a5a, 0, 0);
        rdy = 0; alloc_valid = 1; alloc_rd = 5'd2;
        repeat (3) cycle();
        idle_inputs();
        cycle();
        chk("stall_commit_tag", commit_tag, 1);

        // Mid-operation reset overrides pending work.
        alloc(5'd2, 0); alloc(5'd3, 0);
        do_reset(1);

`ifdef ROB_BYPASS_EN
        alloc(5'd1, 0); alloc(5'd2, 0);
        wb(5'd2, 32'hABCD, 0, 0);
        q1_tag = 5'd2; q2_tag = 5'd1;
        #1;
        chk("q1_ready_dir", q1_ready, 1);
        chk("q1_value_dir", q1_value, 32'hABCD);
        chk("q2_ready_dir", q2_ready, 0);
        idle_inputs();
        drain();
`endif

        // Random traffic.
        for (int c = 0; c < 600; c++) begin
            rdy             = ($urandom_range(0, 9) != 0);
            alloc_valid     = $urandom_range(0, 1);
            alloc_rd        = 5'($urandom_range(0, 31));
            alloc_is_branch = ($urandom_range(0, 3) == 0);
            wb_valid        = $urandom_range(0, 1);
            if (mq.size() > 0 && $urandom_range(0, 3) != 0)
                wb_tag = mq[$urandom_range(0, mq.size() - 1)].tag;
            else
                wb_tag = 5'($urandom_range(0, 31));
            wb_value      = $urandom;
            wb_mispredict = ($urandom_range(0, 7) == 0);
            wb_target     = $urandom;
`ifdef ROB_BYPASS_EN
            q1_tag = 5'($urandom_range(0, DEPTH));
            q2_tag = (mq.size() > 0) ? mq[0].tag : 5'd0;
`endif
            cycle();
        end
        idle_inputs();
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
